// File: rtl/hazard_unit_mc.sv
// Purpose: hazard detection, forwarding selects and a multi-cycle (mult/div) busy tracker for a 5-stage pipeline.
// Latency: forwards, stalls and flush are combinational in the same cycle; McBusy and StallCount update on the clock edge.
// Backpressure: StallF/StallD freeze fetch and decode and FlushE bubbles execute. Nothing is queued: a mult/div waits in decode while the unit is busy.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   RsD, RtD, BranchD, JumpD          decode-stage sources and branch/jump flags
//   McStartD, McReadD                 decode holds a mult/div, or an mfhi/mflo
//   RsE, RtE, WriteRegE, RegWriteE, MemtoRegE   execute-stage info
//   WriteRegM, RegWriteM, MemtoRegM   memory-stage info
//   WriteRegW, RegWriteW              writeback-stage info
//   StallF, StallD, FlushE            pipeline control
//   ForwardAD, ForwardBD              branch comparator forward from M
//   ForwardAE, ForwardBE              execute forward select: 00 regfile, 01 W, 10 M
//   McBusy, StallCount                mult/div in flight; saturating count of stall cycles
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              BranchD,
    input  logic              JumpD,
    input  logic              McStartD,
    input  logic              McReadD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy,
    output logic [CNT_W-1:0]  StallCount
);

    localparam int              MC_CW   = $clog2(MC_LAT + 1);
    localparam logic [MC_CW-1:0] MC_LOAD = MC_CW'(MC_LAT);

    logic [MC_CW-1:0] mcCnt;
    logic             lwStall;
    logic             brStall;
    logic             mcStall;
    logic             stallAny;
    logic             brHitE;
    logic             brHitM;

    // Execute-stage forwarding; the newer result in M wins over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RsE != '0 && RsE == WriteRegM && RegWriteM)
            ForwardAE = 2'b10;
        else if (RsE != '0 && RsE == WriteRegW && RegWriteW)
            ForwardAE = 2'b01;
        if (RtE != '0 && RtE == WriteRegM && RegWriteM)
            ForwardBE = 2'b10;
        else if (RtE != '0 && RtE == WriteRegW && RegWriteW)
            ForwardBE = 2'b01;
    end

    assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
    assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

    // A load in E cannot forward in time to an instruction in D.
    assign lwStall = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));

    // The branch compares in D, so it needs results from E (ALU) and M (load data).
    assign brHitE  = RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign brHitM  = MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD));
    assign brStall = BranchD && (brHitE || brHitM);

    assign McBusy  = (mcCnt != '0);
    assign mcStall = McBusy && (McStartD || McReadD);

    assign stallAny = lwStall || brStall || mcStall;
    assign StallF   = stallAny;
    assign StallD   = stallAny;
    assign FlushE   = stallAny || JumpD;

    // A new mult/div can only issue when the unit is idle, because mcStall holds it in decode.
    always_ff @(posedge clk) begin
        if (rst)
            mcCnt <= '0;
        else if (McStartD && !stallAny)
            mcCnt <= MC_LOAD;
        else if (mcCnt != '0)
            mcCnt <= mcCnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            StallCount <= '0;
        else if (stallAny && (StallCount != {CNT_W{1'b1}}))
            StallCount <= StallCount + 1'b1;
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       BranchD, JumpD, McStartD, McReadD;
    logic       RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;

    logic        StallF, StallD, FlushE, ForwardAD, ForwardBD, McBusy;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    logic        StallF4, StallD4, FlushE4, ForwardAD4, ForwardBD4, McBusy4;
    logic [1:0]  ForwardAE4, ForwardBE4;
    logic [3:0]  StallCount4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_unit_mc dut (
        .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .JumpD(JumpD),
        .McStartD(McStartD), .McReadD(McReadD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegW(WriteRegW),
        .RegWriteW(RegWriteW), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .McBusy(McBusy), .StallCount(StallCount)
    );

    // Second copy: 4-bit counter for saturation, 1-cycle unit for the minimum-latency case.
    hazard_unit_mc #(.REG_AW(5), .MC_LAT(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .JumpD(JumpD),
        .McStartD(McStartD), .McReadD(McReadD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegW(WriteRegW),
        .RegWriteW(RegWriteW), .StallF(StallF4), .StallD(StallD4), .FlushE(FlushE4),
        .ForwardAD(ForwardAD4), .ForwardBD(ForwardBD4), .ForwardAE(ForwardAE4),
        .ForwardBE(ForwardBE4), .McBusy(McBusy4), .StallCount(StallCount4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs then change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        RsD = 0; RtD = 0; BranchD = 0; JumpD = 0; McStartD = 0; McReadD = 0;
        RsE = 0; RtE = 0; WriteRegE = 0; RegWriteE = 0; MemtoRegE = 0;
        WriteRegM = 0; RegWriteM = 0; MemtoRegM = 0; WriteRegW = 0; RegWriteW = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearInputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        doReset();
        #1;
        chk("reset_busy", McBusy, 0);
        chk("reset_count", StallCount, 0);
        chk("reset_stall", StallD, 0);
        chk("reset_flush", FlushE, 0);

        // Forwarding: M has priority over W, and register 0 never forwards.
        RsE = 3; RtE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1; #1;
        chk("fwdAE_M", ForwardAE, 2'b10);
        chk("fwdBE_M", ForwardBE, 2'b10);
        RegWriteM = 0; #1;
        chk("fwdAE_W", ForwardAE, 2'b01);
        RsE = 0; RegWriteM = 1; #1;
        chk("fwdAE_r0", ForwardAE, 2'b00);
        RsD = 3; RtD = 0; #1;
        chk("fwdAD", ForwardAD, 1);
        chk("fwdBD_r0", ForwardBD, 0);
        RegWriteM = 0; #1;
        chk("fwdAD_nowr", ForwardAD, 0);

        // Load-use stall.
        clearInputs();
        MemtoRegE = 1; RtE = 5; RsD = 5; #1;
        chk("lw_stallF", StallF, 1);
        chk("lw_stallD", StallD, 1);
        chk("lw_flush", FlushE, 1);
        RtE = 0; RsD = 0; #1;
        chk("lw_r0_stallF", StallF, 0);
        chk("lw_r0_stallD", StallD, 0);
        chk("lw_r0_flush", FlushE, 0);

        // Branch stall plus jump, counted once per cycle.
        doReset();
        BranchD = 1; RsD = 7; RegWriteE = 1; WriteRegE = 7; JumpD = 1; #1;
        chk("br_stall", StallD, 1);
        chk("br_flush", FlushE, 1);
        tick(); tick(); tick();
        chk("br_count3", StallCount, 3);
        RegWriteE = 0; MemtoRegM = 1; WriteRegM = 7; #1;
        chk("br_M_stall", StallD, 1);
        MemtoRegE = 1; RtE = 7; #1;
        chk("br_lw_both", StallD, 1);
        tick();
        chk("br_lw_once", StallCount, 4);
        clearInputs();
        JumpD = 1; #1;
        chk("jump_flush", FlushE, 1);
        chk("jump_nostall", StallD, 0);

        // Multi-cycle unit, MC_LAT=4 (dut) and MC_LAT=1 (dut4).
        doReset();
        McStartD = 1; #1;
        chk("mc_c0_stall", StallD, 0);
        chk("mc_c0_busy", McBusy, 0);
        tick();
        McStartD = 0; McReadD = 1; #1;
        chk("mc4_c1_busy", McBusy4, 1);
        chk("mc4_c1_stall", StallD4, 1);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("mc_c%0d_busy", c), McBusy, 1);
            chk($sformatf("mc_c%0d_stall", c), StallD, 1);
            if (c == 2) chk("mc4_c2_busy", McBusy4, 0);
            tick();
        end
        chk("mc_c5_busy", McBusy, 0);
        chk("mc_c5_stall", StallD, 0);
        chk("mc_c5_count", StallCount, 4);
        chk("mc4_count", StallCount4, 1);

        // A second mult/div waits in decode until the first finishes.
        McReadD = 0; McStartD = 1; #1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("mc_hold_c%0d_stall", c), StallD, 1);
            tick();
        end
        chk("mc_hold_c5_stall", StallD, 0);
        chk("mc_hold_c5_busy", McBusy, 0);
        tick();
        McStartD = 0; #1;
        chk("mc_reissue_busy", McBusy, 1);
        chk("mc_reissue_count", StallCount, 8);

        // Reset in flight abandons the mult/div.
        doReset();
        McStartD = 1; #1;
        tick();
        McStartD = 0; McReadD = 1; #1;
        tick();
        rst = 1; #1;
        chk("mcrst_comb_stall", StallD, 1);
        tick();
        rst = 0; #1;
        chk("mcrst_busy", McBusy, 0);
        chk("mcrst_stall", StallD, 0);
        chk("mcrst_count", StallCount, 0);

        // Saturation of the 4-bit counter.
        doReset();
        MemtoRegE = 1; RtE = 9; RtD = 9; #1;
        for (int c = 0; c < 20; c++) tick();
        chk("sat_cnt4", StallCount4, 15);
        chk("sat_cnt16", StallCount, 20);
        tick(); tick();
        chk("sat_cnt4_hold", StallCount4, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 Parameter REG_AW, default 5, register-specifier width.
REQ-002 Parameter MC_LAT, default 4, multi-cycle (mult/div) unit latency in cycles; legal range 1..255.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 RsD, RtD  in  REG_AW each  decode-stage source registers.
REQ-007 BranchD, JumpD  in  1 each  decode-stage branch / jump.
REQ-008 McStartD  in  1  decode instruction is mult/div (writes HI/LO).
REQ-009 McReadD  in  1  decode instruction is mfhi/mflo.
REQ-010 RsE, RtE, WriteRegE  in  REG_AW each  execute-stage registers.
REQ-011 RegWriteE, MemtoRegE  in  1 each  execute-stage controls.
REQ-012 WriteRegM  in  REG_AW; RegWriteM, MemtoRegM  in  1 each  memory-stage info.
REQ-013 WriteRegW  in  REG_AW; RegWriteW  in  1  writeback-stage info.
REQ-014 StallF, StallD, FlushE  out  1 each  pipeline control.
REQ-015 ForwardAD, ForwardBD  out  1 each  decode (branch comparator) forward from M.
REQ-016 ForwardAE, ForwardBE  out  2 each  execute forward select: 00 regfile, 01 W, 10 M.
REQ-017 McBusy  out  1  multi-cycle unit in flight.
REQ-018 StallCount  out  CNT_W  saturating count of StallD cycles.

Function
REQ-019 ForwardAE SHALL be 10 if RsE!=0, RsE==WriteRegM, RegWriteM; else 01 if RsE!=0, RsE==WriteRegW, RegWriteW; else 00 (M priority over W); ForwardBE identical using RtE.
REQ-020 ForwardAD SHALL be (RsD!=0 && RsD==WriteRegM && RegWriteM); ForwardBD same with RtD.
REQ-021 lwStall SHALL be MemtoRegE && RtE!=0 && (RsD==RtE || RtD==RtE); register 0 never causes a stall.
REQ-022 brStall SHALL be BranchD && ((RegWriteE && WriteRegE!=0 && WriteRegE in {RsD,RtD}) || (MemtoRegM && WriteRegM!=0 && WriteRegM in {RsD,RtD})).
REQ-023 mcStall SHALL be McBusy && (McStartD || McReadD).
REQ-024 StallF = StallD = lwStall | brStall | mcStall; FlushE = StallD | JumpD; all combinational, same cycle.
REQ-025 Issue SHALL occur on a rising edge where McStartD && !StallD; issue loads internal counter mc_cnt (width ceil(log2(MC_LAT+1))) with MC_LAT.
REQ-026 Absent issue, mc_cnt SHALL decrement by 1 per cycle while nonzero and hold at 0.
REQ-027 McBusy SHALL equal (mc_cnt!=0): high exactly MC_LAT cycles after an issue edge, low on cycle MC_LAT+1, when mfhi/mflo or a new mult/div proceeds.
REQ-028 Issue while busy SHALL be impossible (mcStall blocks it); no overlap/queuing.
REQ-029 StallCount SHALL increment by 1 on each edge with StallD=1, saturating at 2^CNT_W-1 (no wrap).
REQ-030 Stall conditions SHALL be independent; simultaneous lw/branch/mc stall produces one stall cycle per cycle, counted once.

Reset
REQ-031 On a rising edge with rst=1: mc_cnt=0, McBusy=0, StallCount=0; rst overrides issue and decrement in that cycle.
REQ-032 Reset mid-operation SHALL abandon an in-flight mult/div; the next cycle McBusy=0, mcStall=0.
REQ-033 Combinational outputs (forwards, stalls, flush) SHALL follow inputs during reset, with mcStall=0 from the cycle after reset.

Verification
REQ-034 RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> ForwardAE=10; RsE=0 same -> 00.
REQ-035 MemtoRegE=1, RtE=5, RsD=5 -> StallF=StallD=FlushE=1; RtE=0 -> all 0.
REQ-036 MC_LAT=4: McStartD pulse, cycle 0 -> McBusy high cycles 1-4; McReadD held from cycle 1 -> StallD=1 cycles 1-4, 0 at cycle 5, StallCount=4.
REQ-037 Issue mult, rst=1 at cycle 2 -> McBusy=0 at cycle 3, StallCount=0.
REQ-038 CNT_W=4, StallD held 20 cycles -> StallCount=15 and holds.
REQ-039 BranchD=1, RsD=7, RegWriteE=1, WriteRegE=7, plus JumpD=1 -> StallD=1, FlushE=1, StallCount +1 per cycle.
